ps2_key_event_rx: RTL and testbench

Parametrised successor to the PS/2 keyboard receiver. It receives PS/2 device-to-host frames and checks start, stop and odd parity. It decodes scancode-set-2 prefixes (E0 extended, F0 break) into single key events, and buffers those events in a FIFO with a valid/ready consumer handshake. It sits between the PS/2 pins and the system/top-level consumer, and replaces the manual nextdata_n read strobe.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_frame_rx.sv | 86 ++++++++
 rtl/ps2_key_event_rx.sv | 140 ++++++++++++++
 tb/tb_ps2_key_event_rx.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key-event receiver: scancode-set-2 prefixes,
// frame geometry, decoder state encoding and the buffered key-event record.
package ps2_pkg;

  localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    E0,
    F0,
    E0F0
  } dec_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  // Odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pin synchronisers, falling-edge detect,
// 11-bit framing with start/stop/odd-parity checks and a mid-frame watchdog.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_strobe,
  output logic       err_strobe
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic [3:0]             bit_cnt;
  logic [9:0]             shift_q;
  logic [WD_W-1:0]        wd_cnt;
  logic                   last_bit;
  logic                   frame_ok;
  logic                   wd_expired;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  assign last_bit = (bit_cnt == 4'(PS2_FRAME_BITS - 1));
  // shift_q holds start (bit 0), d0..d7 (bits 8:1) and parity (bit 9); data_s is the stop bit.
  assign frame_ok = ~shift_q[0] & data_s & odd_parity_ok(shift_q[8:1], shift_q[9]);

  assign wd_expired = (bit_cnt != '0) && !fall && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      bit_cnt     <= '0;
      shift_q     <= '0;
      wd_cnt      <= '0;
      rx_byte     <= '0;
      byte_strobe <= 1'b0;
      err_strobe  <= 1'b0;
    end else begin
      byte_strobe <= fall && last_bit && frame_ok;
      err_strobe  <= (fall && last_bit && !frame_ok) || wd_expired;
      if (fall) begin
        wd_cnt <= '0;
        if (last_bit) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            rx_byte <= shift_q[8:1];
          end
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          shift_q <= {data_s, shift_q[9:1]};
        end
      end else if (wd_expired) begin
        bit_cnt <= '0;
        wd_cnt  <= '0;
      end else if (bit_cnt != '0) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frames bytes, folds E0/F0 prefixes into single key
// events and buffers them in a show-ahead FIFO with a valid/ready handshake.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        clrn,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic [7:0]                  ev_code,
  output logic                        ev_ext,
  output logic                        ev_release,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        clr_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0] rx_byte;
  logic       byte_strobe;
  logic       err_strobe;

  ps2_frame_rx #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk        (clk),
    .clrn       (clrn),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_strobe(byte_strobe),
    .err_strobe (err_strobe)
  );

  dec_state_e state_q;
  dec_state_e state_d;
  logic       emit;
  key_event_t ev_new;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    ev_new  = '0;
    if (byte_strobe) begin
      if (rx_byte == PS2_PREFIX_EXT) begin
        // Any E0 restarts the prefix as an extended make, even after a lone F0.
        state_d = E0;
      end else if (rx_byte == PS2_PREFIX_BRK) begin
        state_d = (state_q == E0 || state_q == E0F0) ? E0F0 : F0;
      end else begin
        emit        = 1'b1;
        ev_new.code = rx_byte;
        state_d     = IDLE;
        unique case (state_q)
          IDLE: begin ev_new.ext = 1'b0; ev_new.rel = 1'b0; end
          E0:   begin ev_new.ext = 1'b1; ev_new.rel = 1'b0; end
          F0:   begin ev_new.ext = 1'b0; ev_new.rel = 1'b1; end
          E0F0: begin ev_new.ext = 1'b1; ev_new.rel = 1'b1; end
          default: begin ev_new.ext = 1'b0; ev_new.rel = 1'b0; end
        endcase
      end
    end
  end

  key_event_t     mem [FIFO_DEPTH];
  key_event_t     head;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           full;
  logic           pop;
  logic           push;

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign ev_valid = (count_q != '0);
  assign pop      = ev_valid & ev_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push     = emit & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ev_new;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overflow  <= (overflow & ~clr_err) | (emit & full & ~pop);
      frame_err <= (frame_err & ~clr_err) | err_strobe;
    end
  end

  assign head       = mem[rd_ptr];
  assign ev_code    = ev_valid ? head.code : '0;
  assign ev_ext     = ev_valid & head.ext;
  assign ev_release = ev_valid & head.rel;
  assign ev_count   = count_q;

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Scoreboard bench for ps2_key_event_rx: bit-banged PS/2 frames, a prefix-flag
// reference model feeding an expected-event queue, and a decoupled output monitor.
`timescale 1ns/1ps
module tb_ps2_key_event_rx;
  import ps2_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 300;
  localparam int unsigned HALF    = 15;

  logic       clk = 1'b0;
  logic       clrn;
  logic       ps2_clk;
  logic       ps2_data;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;
  logic [2:0] ev_count;
  logic       overflow;
  logic       frame_err;
  logic       clr_err;

  always #5 clk = ~clk;

  ps2_key_event_rx #(
    .FIFO_DEPTH    (DEPTH),
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_code   (ev_code),
    .ev_ext    (ev_ext),
    .ev_release(ev_release),
    .ev_count  (ev_count),
    .overflow  (overflow),
    .frame_err (frame_err),
    .clr_err   (clr_err)
  );

  key_event_t exp_q[$];
  bit         m_ext, m_rel;
  bit         exp_ovf, exp_ferr;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Prefix bytes only set flags; any other byte becomes an event carrying them.
  task automatic model_byte(input logic [7:0] b, input bit coincide);
    key_event_t ev;
    if (b == 8'hE0) begin
      m_ext = 1'b1;
      m_rel = 1'b0;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      ev.ext  = m_ext;
      ev.rel  = m_rel;
      ev.code = b;
      m_ext   = 1'b0;
      m_rel   = 1'b0;
      if (exp_q.size() < DEPTH || coincide) exp_q.push_back(ev);
      else exp_ovf = 1'b1;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input bit chk_lat, input bit coincide);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = f[10];
    wait_cyc(HALF);
    if (bad) exp_ferr = 1'b1;
    else model_byte(b, coincide);
    ps2_clk = 1'b0;
    // Two sync flops: edge seen 2 cycles after driving, strobe one later, FIFO write one after that.
    wait_cyc(3);
    if (coincide) ev_ready = 1'b1;
    @(negedge clk);
    if (chk_lat) check("latency_t1_valid", int'(ev_valid), 0);
    @(posedge clk);
    #1;
    if (coincide) ev_ready = 1'b0;
    @(negedge clk);
    if (chk_lat) check("latency_t2_valid", int'(ev_valid), 1);
    wait_cyc(HALF);
    ps2_clk = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    wait_cyc(1);
    clr_err  = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    wait_cyc(1);
  endtask

  task automatic chk_state(input string name);
    @(negedge clk);
    check({name, "_count"}, int'(ev_count), exp_q.size());
    check({name, "_overflow"}, int'(overflow), int'(exp_ovf));
    check({name, "_frame_err"}, int'(frame_err), int'(exp_ferr));
    wait_cyc(1);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    ev_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      wait_cyc(1);
      k++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
    wait_cyc(2);
    ev_ready = 1'b0;
    @(negedge clk);
    check({name, "_empty_valid"}, int'(ev_valid), 0);
    check({name, "_empty_count"}, int'(ev_count), 0);
    wait_cyc(1);
  endtask

  // Monitor: every accepted head event must match the oldest expected one.
  initial begin
    key_event_t e;
    forever begin
      @(negedge clk);
      if (clrn && ev_valid && ev_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got code=%h ext=%0d rel=%0d, required no event",
                   ev_code, ev_ext, ev_release);
        end else begin
          e = exp_q.pop_front();
          if ({ev_ext, ev_release, ev_code} != {e.ext, e.rel, e.code}) begin
            n_fail++;
            $display("FAIL event: got code=%h ext=%0d rel=%0d, required code=%h ext=%0d rel=%0d",
                     ev_code, ev_ext, ev_release, e.code, e.ext, e.rel);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL global_timeout: simulation still running, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] b;
    int         nf;
    clrn     = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    ev_ready = 1'b0;
    clr_err  = 1'b0;
    m_ext    = 1'b0;
    m_rel    = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    wait_cyc(5);
    @(negedge clk);
    check("reset_valid", int'(ev_valid), 0);
    check("reset_count", int'(ev_count), 0);
    check("reset_code", int'(ev_code), 0);
    check("reset_ext_rel", int'({ev_ext, ev_release}), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_frame_err", int'(frame_err), 0);
    wait_cyc(1);
    clrn = 1'b1;
    wait_cyc(5);

    // Single make code with latency checks
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    chk_state("make_1c");
    drain("make_1c");

    // Extended break and plain break
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 1'b0);
    chk_state("prefixes");
    drain("prefixes");

    // Parity error, clear, then recovery
    send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
    chk_state("parity_err");
    clear_errs();
    chk_state("parity_cleared");
    send_frame(8'h32, 1'b0, 1'b0, 1'b0);
    drain("after_parity");

    // Partial frame abandoned by the watchdog
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    wait_cyc(TIMEOUT + 100);
    exp_ferr = 1'b1;
    chk_state("timeout");
    clear_errs();
    send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    chk_state("after_timeout");
    drain("after_timeout");

    // Overflow, then pop coinciding with push on a full FIFO
    send_frame(8'h11, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    chk_state("overflow");
    clear_errs();
    send_frame(8'h66, 1'b0, 1'b0, 1'b1);
    chk_state("full_pop_push");
    drain("overflow");

    // Randomised rounds: fill with ready low, check flags, drain
    for (int r = 0; r < 8; r++) begin
      nf = $urandom_range(1, 7);
      for (int j = 0; j < nf; j++) begin
        case ($urandom_range(0, 9))
          0, 1:    b = 8'hE0;
          2:       b = 8'hF0;
          default: b = 8'($urandom_range(0, 255));
        endcase
        send_frame(b, ($urandom_range(0, 9) == 0), 1'b0, 1'b0);
      end
      chk_state("random");
      drain("random");
      clear_errs();
    end

    // Reset mid-frame after an E0 prefix discards the pending prefix
    m_ext = 1'b0;
    m_rel = 1'b0;
    send_frame(8'hE0, 1'b0, 1'b0, 1'b0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    clrn = 1'b0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    @(negedge clk);
    check("midreset_valid", int'(ev_valid), 0);
    check("midreset_count", int'(ev_count), 0);
    check("midreset_code", int'(ev_code), 0);
    check("midreset_flags", int'({overflow, frame_err}), 0);
    wait_cyc(3);
    clrn = 1'b1;
    wait_cyc(5);
    send_frame(8'h6B, 1'b0, 1'b0, 1'b0);
    chk_state("after_reset");
    drain("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
